// File: rtl/hs_slave_fifo_pkg.sv
// Shared definitions for the valid/ready handshake link: derived widths,
// reset data value and the beat type carried on the link.
package hs_slave_fifo_pkg;

   // Standard beat width of the link.
   localparam int HS_BEAT_W = 8;

   // Each data bit takes this value on reset or when no beat is presented.
   localparam bit HS_RST_DATA_BIT = 1'b0;

   // One beat as seen on either side of the link.
   typedef struct packed {
      logic                 valid;
      logic [HS_BEAT_W-1:0] data;
   } hs_beat_t;

   // Pointer width for a power-of-two DEPTH (at least one bit).
   function automatic int hs_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy width: must represent 0..DEPTH inclusive.
   function automatic int hs_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hs_slave_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module hs_fifo_mem
   import hs_slave_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = hs_ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Store the incoming beat at the write address.
   // NOTE: storage is deliberately not reset; occupancy and pointers alone
   // decide which entries are meaningful, so stale contents are never seen.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hs_slave_fifo.sv
// Receive-side valid/ready endpoint with a DEPTH-entry show-ahead FIFO and a
// registered upstream ready that drops before the buffer can overflow.
module hs_slave_fifo
   import hs_slave_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ready_en,
   input  logic                       valid,
   input  logic [WIDTH-1:0]           sdata_in,
   output logic                       ready,
   output logic [WIDTH-1:0]           sdata_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [CNT_W-1:0]           beats,
   output logic                       overflow
);

   localparam int PTR_W = hs_ptr_w(DEPTH);
   localparam int OCC_W = hs_cnt_w(DEPTH);
   localparam logic [WIDTH-1:0] RST_DATA = {WIDTH{HS_RST_DATA_BIT}};

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_count;
   logic             r_ready;
   logic [CNT_W-1:0] r_beats;
   logic             r_overflow;

   logic             w_push;
   logic             w_pop;
   logic             w_out_valid;
   logic [OCC_W-1:0] w_count_next;
   logic [WIDTH-1:0] w_rdata;

   assign w_out_valid = (r_count != '0);
   assign w_push      = valid && r_ready;
   assign w_pop       = w_out_valid && out_ready;

   // Next occupancy: simultaneous push and pop cancel out.
   // NOTE: the default assignment first keeps every path driven, so no latch
   // is inferred for w_count_next.
   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + OCC_W'(1);
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - OCC_W'(1);
      end
   end

   // Pointers, occupancy, registered ready, beat counter and overflow flag.
   // NOTE: non-blocking assignments keep every register updating from the
   // same pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_ready    <= 1'b0;
         r_beats    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_beats  <= r_beats + CNT_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_next;
         // Ready only when at least one entry will be free next cycle.
         r_ready <= ready_en && (w_count_next <= OCC_W'(DEPTH - 1));
         // Consistency check: a write into a full buffer must never happen.
         if (w_push && (r_count == OCC_W'(DEPTH))) begin
            r_overflow <= 1'b1;
         end
      end
   end

   hs_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PTR_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (sdata_in),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign ready     = r_ready;
   assign out_valid = w_out_valid;
   assign sdata_out = w_out_valid ? w_rdata : RST_DATA;
   assign count     = r_count;
   assign beats     = r_beats;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_hs_slave_fifo.sv
// Scoreboard bench for hs_slave_fifo: a queue-based reference model tracks
// accepted beats; a negedge monitor compares every visible output to it.
module tb_hs_slave_fifo;
   import hs_slave_fifo_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ready_en = 1'b1;
   logic             valid = 1'b1;
   logic [WIDTH-1:0] sdata_in = 8'hAA;
   logic             out_ready = 1'b0;
   logic             ready;
   logic [WIDTH-1:0] sdata_out;
   logic             out_valid;
   logic [OCC_W-1:0] count;
   logic [CNT_W-1:0] beats;
   logic             overflow;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state.
   hs_beat_t         q[$];
   logic             exp_ready = 1'b0;
   logic [CNT_W-1:0] exp_beats = '0;
   int               n_push = 0;
   bit               armed = 1'b0;

   hs_slave_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ready_en  (ready_en),
      .valid     (valid),
      .sdata_in  (sdata_in),
      .ready     (ready),
      .sdata_out (sdata_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .beats     (beats),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: the buffer is a queue; a beat is taken when valid meets
   // the ready the model predicted; ready is predicted from the new occupancy.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         exp_ready = 1'b0;
         exp_beats = '0;
         n_push    = 0;
         armed     = 1'b1;
      end else if (armed) begin
         if (q.size() != 0 && out_ready) q.delete(0);
         if (valid && exp_ready) begin
            hs_beat_t b;
            b.valid = 1'b1;
            b.data  = sdata_in;
            q.push_back(b);
            exp_beats = exp_beats + 1'b1;
            n_push++;
         end
         exp_ready = ready_en && (q.size() < DEPTH);
      end
   end

   // Monitor: compare all outputs away from the active edge.
   always @(negedge clk) begin
      if (armed) begin
         check("ready", ready, exp_ready);
         check("count", count, q.size());
         check("out_valid", out_valid, q.size() != 0);
         check("sdata_out", sdata_out, (q.size() != 0) ? q[0].data : 8'h00);
         check("beats", beats, exp_beats);
         check("overflow", overflow, 1'b0);
      end
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one beat and hold it until accepted (bounded).
   task automatic send(input logic [WIDTH-1:0] d, input int limit);
      logic acc;
      bit   sent;
      sent     = 1'b0;
      valid    = 1'b1;
      sdata_in = d;
      for (int k = 0; k < limit && !sent; k++) begin
         @(negedge clk);
         acc = ready;
         @(posedge clk);
         #1;
         if (acc) sent = 1'b1;
      end
      valid = 1'b0;
      check("send_accepted", sent, 1'b1);
   endtask

   task automatic drain(input int limit);
      bit done;
      done      = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < limit && !done; k++) begin
         if (q.size() == 0) done = 1'b1;
         else step(1);
      end
      out_ready = 1'b0;
      check("drain_done", done, 1'b1);
   endtask

   task automatic do_reset(input int n);
      rst   = 1'b1;
      valid = 1'b0;
      step(n);
      rst = 1'b0;
      check("ready_after_reset", ready, 1'b0);
      step(1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic acc;

      // Reset held three cycles with traffic presented.
      step(3);
      check("rst_sdata_out", sdata_out, 8'h00);
      check("rst_count", count, 0);
      rst   = 1'b0;
      valid = 1'b0;
      check("first_post_reset_ready", ready, 1'b0);
      step(1);
      check("second_edge_ready", ready, 1'b1);

      // Single beat, then pop it.
      send(8'h5A, 5);
      check("single_out_valid", out_valid, 1'b1);
      check("single_data", sdata_out, 8'h5A);
      check("single_count", count, 1);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      check("single_popped_valid", out_valid, 1'b0);
      check("single_popped_data", sdata_out, 8'h00);

      // Fill to DEPTH, then offer beats that must be refused.
      do_reset(2);
      for (int i = 1; i <= DEPTH; i++) send(WIDTH'(i), 5);
      check("full_count", count, DEPTH);
      check("full_ready", ready, 1'b0);
      valid    = 1'b1;
      sdata_in = 8'h55;
      step(3);
      valid = 1'b0;
      check("full_beats", beats, DEPTH);
      check("full_overflow", overflow, 1'b0);

      // One pop from full returns ready; then stream with concurrent pop.
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      check("pop_from_full_ready", ready, 1'b1);
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) send(WIDTH'(i), 5);
      check("stream_count_const", count, DEPTH - 1);
      drain(20);

      // ready_en drop while streaming at count=1.
      do_reset(1);
      send(8'h10, 5);
      valid    = 1'b1;
      sdata_in = 8'h11;
      ready_en = 1'b0;
      step(1);
      sdata_in = 8'h12;
      step(3);
      valid = 1'b0;
      check("en_drop_beats", beats, 2);
      check("en_drop_ready", ready, 1'b0);
      drain(20);
      ready_en = 1'b1;

      // Beat counter wrap: 17 beats with CNT_W=4 leaves beats=1.
      do_reset(1);
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) send(WIDTH'(8'h20 + i), 5);
      out_ready = 1'b0;
      check("wrap_beats", beats, 1);
      drain(20);

      // Reset mid-stream with three beats buffered.
      for (int i = 0; i < 3; i++) send(WIDTH'(8'h60 + i), 5);
      check("pre_reset_count", count, 3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("mid_reset_count", count, 0);
      check("mid_reset_valid", out_valid, 1'b0);
      check("mid_reset_data", sdata_out, 8'h00);
      step(3);
      send(8'h77, 5);
      check("post_reset_head", sdata_out, 8'h77);
      drain(10);

      // Randomised traffic; the master holds each beat until accepted.
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         acc = valid && ready;
         @(posedge clk);
         #1;
         if (acc) valid = 1'b0;
         if (!valid && $urandom_range(0, 2) != 0) begin
            valid    = 1'b1;
            sdata_in = WIDTH'($urandom);
         end
         out_ready = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         ready_en  = ($urandom_range(0, 7) != 0);
      end
      // Let any held beat land, then empty the buffer.
      ready_en = 1'b1;
      for (int k = 0; k < 20 && valid; k++) begin
         @(negedge clk);
         acc = ready;
         @(posedge clk);
         #1;
         if (acc) valid = 1'b0;
      end
      check("random_master_idle", valid, 1'b0);
      drain(20);
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
